// File: rtl/dram_write_packer_pkg.sv
// Shared configuration and merge-buffer state encoding for the DRAM write packer.
package dram_write_packer_pkg;

  localparam int unsigned GLOBAL_ADDR_BW = 32;
  localparam int unsigned DATA_BW        = 32;
  localparam int unsigned VEC_SIZE       = 4;
  localparam int unsigned CACHE_SIZE     = 8;

  typedef enum logic [1:0] {
    WB_EMPTY      = 2'd0,
    WB_FILL       = 2'd1,
    WB_FLUSH_PEND = 2'd2
  } wbuf_state_e;

endpackage

// File: rtl/wpack_lane_scatter.sv
// Places input vector lanes into chunk word slots; i_remainder selects the
// lanes that spill past the chunk end of a straddling vector.
module wpack_lane_scatter #(
  parameter int unsigned DBW   = 32,
  parameter int unsigned VSIZE = 4,
  parameter int unsigned CSIZE = 8,
  localparam int unsigned CC_BW  = $clog2(CSIZE),
  localparam int unsigned CV_BW1 = $clog2(VSIZE + 1)
) (
  input  logic [CC_BW-1:0]            i_offset,
  input  logic [CV_BW1-1:0]           i_len,
  input  logic                        i_remainder,
  input  logic [VSIZE-1:0][DBW-1:0]   i_data,
  input  logic [CSIZE-1:0][DBW-1:0]   i_buf_data,
  input  logic [CSIZE-1:0]            i_buf_mask,
  output logic [CSIZE-1:0][DBW-1:0]   o_data,
  output logic [CSIZE-1:0]            o_mask,
  output logic                        o_split
);

  localparam int unsigned POS_W = CC_BW + 1;

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] end_pos;

  // Bit CC_BW of a lane position tells which of the two chunks it lands in.
  always_comb begin
    o_data = i_buf_data;
    o_mask = i_buf_mask;
    pos    = '0;
    for (int unsigned i = 0; i < VSIZE; i++) begin
      pos = POS_W'(i_offset) + POS_W'(i);
      if ((CV_BW1'(i) < i_len) && (pos[CC_BW] == i_remainder)) begin
        o_data[pos[CC_BW-1:0]] = i_data[i];
        o_mask[pos[CC_BW-1:0]] = 1'b1;
      end
    end
  end

  assign end_pos = POS_W'(i_offset) + POS_W'(i_len);
  assign o_split = !i_remainder && (end_pos > POS_W'(CSIZE));

endmodule

// File: rtl/dram_write_packer.sv
// Packs contiguous vector writes into CSIZE-aligned masked DRAM chunks.
// Optional idle-flush timer enabled by defining WPACK_TIMEOUT_EN.
module dram_write_packer
  import dram_write_packer_pkg::*;
#(
  parameter int unsigned GBW   = GLOBAL_ADDR_BW,
  parameter int unsigned DBW   = DATA_BW,
  parameter int unsigned VSIZE = VEC_SIZE,
  parameter int unsigned CSIZE = CACHE_SIZE,
`ifdef WPACK_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 15,
`endif
  localparam int unsigned CC_BW  = $clog2(CSIZE),
  localparam int unsigned CV_BW1 = $clog2(VSIZE + 1),
  localparam int unsigned TAG_BW = GBW - CC_BW
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       vecwr_rdy,
  output logic                       vecwr_ack,
  input  logic [GBW-1:0]             i_vecwr_addr,
  input  logic [CV_BW1-1:0]          i_vecwr_len,
  input  logic                       i_vecwr_islast,
  input  logic [VSIZE-1:0][DBW-1:0]  i_vecwr_data,
  output logic                       dramw_rdy,
  input  logic                       dramw_ack,
  output logic [GBW-1:0]             o_dramw_addr,
  output logic [CSIZE-1:0][DBW-1:0]  o_dramw_data,
  output logic [CSIZE-1:0]           o_dramw_mask,
  output logic                       o_idle
);

  wbuf_state_e                st_q, st_d;
  logic [TAG_BW-1:0]          tag_q, tag_d;
  logic [CSIZE-1:0][DBW-1:0]  data_q, data_d;
  logic [CSIZE-1:0]           mask_q, mask_d;
  logic                       last_q, last_d;
  logic                       split_q, split_d;
  logic                       out_vld_q, out_vld_d;
  logic [GBW-1:0]             out_addr_q, out_addr_d;
  logic [CSIZE-1:0][DBW-1:0]  out_data_q, out_data_d;
  logic [CSIZE-1:0]           out_mask_q, out_mask_d;
  logic                       idle_q, idle_d;

  logic [TAG_BW-1:0]          eff_tag_c;
  logic [CSIZE-1:0]           base_mask_c;
  logic [CSIZE-1:0][DBW-1:0]  sc_data_c;
  logic [CSIZE-1:0]           sc_mask_c;
  logic                       sc_split_c;
  logic                       out_free_c, flush_c, flush_go_c, merge_c, merge_go_c;
  logic                       timeout_c;

  // While a straddling vector is half absorbed, its remainder targets the next chunk.
  assign eff_tag_c   = split_q ? (i_vecwr_addr[GBW-1:CC_BW] + TAG_BW'(1))
                               : i_vecwr_addr[GBW-1:CC_BW];
  assign base_mask_c = (st_q == WB_EMPTY) ? '0 : mask_q;

  wpack_lane_scatter #(
    .DBW   (DBW),
    .VSIZE (VSIZE),
    .CSIZE (CSIZE)
  ) u_scatter (
    .i_offset    (i_vecwr_addr[CC_BW-1:0]),
    .i_len       (i_vecwr_len),
    .i_remainder (split_q),
    .i_data      (i_vecwr_data),
    .i_buf_data  (data_q),
    .i_buf_mask  (base_mask_c),
    .o_data      (sc_data_c),
    .o_mask      (sc_mask_c),
    .o_split     (sc_split_c)
  );

  assign out_free_c = !out_vld_q || dramw_ack;
  assign flush_c    = (st_q != WB_EMPTY) &&
                      ((st_q == WB_FLUSH_PEND) || (&mask_q) || last_q || timeout_c ||
                       (vecwr_rdy && (eff_tag_c != tag_q)));
  assign flush_go_c = flush_c && out_free_c;
  assign merge_c    = vecwr_rdy && (st_q != WB_FLUSH_PEND) &&
                      ((st_q == WB_EMPTY) || (eff_tag_c == tag_q));
  assign merge_go_c = !flush_c && merge_c;
  assign vecwr_ack  = merge_go_c && !sc_split_c;

`ifdef WPACK_TIMEOUT_EN
  localparam int unsigned TO_BW = $clog2(TIMEOUT + 1);

  logic [TO_BW-1:0] to_cnt_q, to_cnt_d;

  assign timeout_c = (to_cnt_q == TO_BW'(TIMEOUT));

  // Counts idle cycles of a partially filled buffer; saturates at TIMEOUT.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (flush_go_c || merge_go_c) begin
      to_cnt_d = '0;
    end else if ((st_q == WB_FILL) && !timeout_c) begin
      to_cnt_d = to_cnt_q + TO_BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Merge-buffer FSM and output stage next-state logic.
  always_comb begin
    st_d       = st_q;
    tag_d      = tag_q;
    data_d     = data_q;
    mask_d     = mask_q;
    last_d     = last_q;
    split_d    = split_q;
    out_vld_d  = out_vld_q && !dramw_ack;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    if (flush_go_c) begin
      out_vld_d  = 1'b1;
      out_addr_d = {tag_q, CC_BW'(0)};
      out_data_d = data_q;
      out_mask_d = mask_q;
      st_d       = WB_EMPTY;
      data_d     = '0;
      mask_d     = '0;
      last_d     = 1'b0;
    end else if (flush_c) begin
      st_d = WB_FLUSH_PEND;
    end else if (merge_c) begin
      tag_d  = eff_tag_c;
      data_d = sc_data_c;
      mask_d = sc_mask_c;
      if (sc_split_c) begin
        st_d    = WB_FLUSH_PEND;
        split_d = 1'b1;
      end else begin
        st_d    = WB_FILL;
        split_d = 1'b0;
        last_d  = last_q || i_vecwr_islast;
      end
    end
    idle_d = (st_d == WB_EMPTY) && !out_vld_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st_q       <= WB_EMPTY;
      tag_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      split_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_mask_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      st_q       <= st_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      split_q    <= split_d;
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      idle_q     <= idle_d;
    end
  end

  assign dramw_rdy    = out_vld_q;
  assign o_dramw_addr = out_addr_q;
  assign o_dramw_data = out_data_q;
  assign o_dramw_mask = out_mask_q;
  assign o_idle       = idle_q;

endmodule
